// File: rtl/sysid_check_pkg.sv
// sysid_check_pkg: shared state encoding, word addresses and
// default expected values for the system-ID checker.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WT_ID,
    S_RD_TS,
    S_WT_TS,
    S_FINISH
  } state_t;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'h8765_4321;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'h6951_52E4;

  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_MAX_RETRY      = 2;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// sysid_check_ctrl_if: Avalon-MM read-only master bundle
// between the checker and the system-ID peripheral.
interface sysid_check_ctrl_if;

  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata,
    input  m_readdatavalid
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata,
    output m_readdatavalid
  );

endinterface

// File: rtl/sysid_check_timer.sv
// sysid_check_timer: loadable down-counter that parks at zero
// and flags expiry, used to bound the wait for read data.
module sysid_check_timer #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  input  logic         i_en,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads system ID and build timestamp over
// Avalon-MM, compares both, retries on response timeout.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int          MAX_RETRY      = DEF_MAX_RETRY,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  sysid_check_ctrl_if.master avm,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        err_id,
  output logic        err_ts,
  output logic        err_timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int TW = cnt_width(TIMEOUT_CYCLES + 1);
  localparam int RW = cnt_width(MAX_RETRY + 1);

  state_t        r_state;
  state_t        w_next;
  logic [RW-1:0] r_retry;
  logic          r_auto;
  logic          r_pass;
  logic          r_err_id;
  logic          r_err_ts;
  logic          r_err_to;
  logic [31:0]   r_id;
  logic [31:0]   r_ts;

  logic w_in_rd;
  logic w_in_wt;
  logic w_accept;
  logic w_rdv;
  logic w_tmo;
  logic w_last;
  logic w_launch;
  logic w_expired;
  logic w_id_bad;
  logic w_ts_bad;

  assign w_in_rd  = (r_state == S_RD_ID) ||
                    (r_state == S_RD_TS);
  assign w_in_wt  = (r_state == S_WT_ID) ||
                    (r_state == S_WT_TS);
  assign w_accept = w_in_rd && !avm.m_waitrequest;
  assign w_rdv    = w_in_wt && avm.m_readdatavalid;
  assign w_tmo    = w_in_wt && !avm.m_readdatavalid &&
                    w_expired;
  assign w_last   = (r_retry == RW'(MAX_RETRY));
  assign w_launch = (r_state == S_IDLE) &&
                    (start || r_auto);
  assign w_id_bad = (avm.m_readdata != EXPECTED_ID);
  assign w_ts_bad = (avm.m_readdata != EXPECTED_TS);

  // Loaded with N-1 so a wait state lasts at most N cycles.
  sysid_check_timer #(
    .W (TW)
  ) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_load    (w_accept),
    .i_value   (TW'(TIMEOUT_CYCLES - 1)),
    .i_en      (w_in_wt),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start || r_auto) w_next = S_RD_ID;
      end
      S_RD_ID: begin
        if (!avm.m_waitrequest) w_next = S_WT_ID;
      end
      S_WT_ID: begin
        if (avm.m_readdatavalid) begin
          w_next = S_RD_TS;
        end else if (w_expired) begin
          w_next = w_last ? S_FINISH : S_RD_ID;
        end
      end
      S_RD_TS: begin
        if (!avm.m_waitrequest) w_next = S_WT_TS;
      end
      S_WT_TS: begin
        if (avm.m_readdatavalid) begin
          w_next = S_FINISH;
        end else if (w_expired) begin
          w_next = w_last ? S_FINISH : S_RD_TS;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    avm.m_read    = 1'b0;
    avm.m_address = ADDR_ID;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    unique case (r_state)
      S_RD_ID: begin
        avm.m_read    = 1'b1;
        avm.m_address = ADDR_ID;
      end
      S_RD_TS: begin
        avm.m_read    = 1'b1;
        avm.m_address = ADDR_TS;
      end
      S_FINISH: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // pass is settled on entry to FINISH so it is valid with done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_auto   <= AUTO_START;
      r_retry  <= '0;
      r_pass   <= 1'b0;
      r_err_id <= 1'b0;
      r_err_ts <= 1'b0;
      r_err_to <= 1'b0;
      r_id     <= '0;
      r_ts     <= '0;
    end else if (w_launch) begin
      r_auto   <= 1'b0;
      r_retry  <= '0;
      r_pass   <= 1'b0;
      r_err_id <= 1'b0;
      r_err_ts <= 1'b0;
      r_err_to <= 1'b0;
    end else if (w_rdv) begin
      r_retry <= '0;
      if (r_state == S_WT_ID) begin
        r_id     <= avm.m_readdata;
        r_err_id <= w_id_bad;
      end else begin
        r_ts     <= avm.m_readdata;
        r_err_ts <= w_ts_bad;
        r_pass   <= !(r_err_id | w_ts_bad | r_err_to);
      end
    end else if (w_tmo) begin
      if (w_last) begin
        r_err_to <= 1'b1;
        r_pass   <= 1'b0;
      end else begin
        r_retry <= r_retry + 1'b1;
      end
    end
  end

  assign pass        = r_pass;
  assign err_id      = r_err_id;
  assign err_ts      = r_err_ts;
  assign err_timeout = r_err_to;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: scoreboard bench with an Avalon-MM
// responder model driving directed check scenarios.
module tb_sysid_check_ctrl;

  localparam logic [31:0] EID = 32'h8765_4321;
  localparam logic [31:0] ETS = 32'h6951_52E4;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic        err_id;
  logic        err_ts;
  logic        err_timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  sysid_check_ctrl_if bus ();

  sysid_check_ctrl #(
    .EXPECTED_ID    (EID),
    .EXPECTED_TS    (ETS),
    .TIMEOUT_CYCLES (8),
    .MAX_RETRY      (2),
    .AUTO_START     (1'b1)
  ) u_dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .avm         (bus),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .err_id      (err_id),
    .err_ts      (err_ts),
    .err_timeout (err_timeout),
    .id_value    (id_value),
    .ts_value    (ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        p;
    logic        ei;
    logic        et;
    logic        eto;
    logic [31:0] id;
    logic [31:0] ts;
    int          b0;
    int          b1;
    int          n0;
    int          n1;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  int tests = 0;
  int fails = 0;

  logic [31:0] cfg_data[2];
  int          cfg_delay[2];
  bit          cfg_noresp[2];
  int          cfg_wait = 0;
  int          rd_cnt[2];

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(input logic p, ei, et, eto,
                              input logic [31:0] id, ts,
                              input int n0, n1, lat);
    exp_t e;
    e.p   = p;
    e.ei  = ei;
    e.et  = et;
    e.eto = eto;
    e.id  = id;
    e.ts  = ts;
    e.b0  = rd_cnt[0];
    e.b1  = rd_cnt[1];
    e.n0  = n0;
    e.n1  = n1;
    e.t0  = cyc;
    e.lat = lat;
    return e;
  endfunction

  // Responder: stalls cfg_wait cycles, and also while a
  // response is still owed, then answers after cfg_delay.
  initial begin
    int          wcnt;
    int          rcnt;
    logic [31:0] rdata;
    logic        haddr;
    int          a;
    wcnt  = 0;
    rcnt  = -1;
    rdata = '0;
    haddr = 1'b0;
    bus.m_waitrequest   = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.m_readdatavalid = 1'b0;
      bus.m_waitrequest   = 1'b0;
      if (rcnt > 0) rcnt--;
      if (rcnt == 0) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = rdata;
        rcnt = -1;
      end
      if (bus.m_read === 1'b1) begin
        a = int'(bus.m_address);
        if (wcnt > 0) chk("addr_hold", 32'(bus.m_address),
                          32'(haddr));
        if (wcnt < cfg_wait || rcnt >= 0) begin
          bus.m_waitrequest = 1'b1;
          if (wcnt == 0) haddr = bus.m_address;
          wcnt++;
        end else begin
          rd_cnt[a]++;
          wcnt = 0;
          if (!cfg_noresp[a]) begin
            rcnt  = cfg_delay[a];
            rdata = cfg_data[a];
          end
        end
      end else if (wcnt > 0) begin
        chk("read_hold", 32'(bus.m_read), 32'd1);
        wcnt = 0;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 want 0 (cycle %0d)",
                   cyc);
        end else begin
          e = sbq.pop_front();
          chk("pass", 32'(pass), 32'(e.p));
          chk("err_id", 32'(err_id), 32'(e.ei));
          chk("err_ts", 32'(err_ts), 32'(e.et));
          chk("err_timeout", 32'(err_timeout), 32'(e.eto));
          chk("id_value", id_value, e.id);
          chk("ts_value", ts_value, e.ts);
          chk("reads_a0", 32'(rd_cnt[0] - e.b0), 32'(e.n0));
          chk("reads_a1", 32'(rd_cnt[1] - e.b1), 32'(e.n1));
          if (e.lat >= 0)
            chk("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done: got no done in %0d cycles want done",
               budget);
      sbq.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic run_check(input logic [31:0] d0, d1,
                           input int wt,
                           input bit nr0, nr1,
                           input logic p, ei, et, eto,
                           input logic [31:0] id, ts,
                           input int n0, n1, lat);
    cfg_data[0]   = d0;
    cfg_data[1]   = d1;
    cfg_wait      = wt;
    cfg_noresp[0] = nr0;
    cfg_noresp[1] = nr1;
    @(posedge clock);
    #1;
    sbq.push_back(mk(p, ei, et, eto, id, ts, n0, n1, lat));
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_sb(400);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base1;
    cfg_data[0]   = EID;
    cfg_data[1]   = ETS;
    cfg_delay[0]  = 1;
    cfg_delay[1]  = 1;
    cfg_noresp[0] = 1'b0;
    cfg_noresp[1] = 1'b0;
    rd_cnt[0]     = 0;
    rd_cnt[1]     = 0;

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_m_read", 32'(bus.m_read), 32'd0);
    chk("rst_m_address", 32'(bus.m_address), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err_id", 32'(err_id), 32'd0);
    chk("rst_err_ts", 32'(err_ts), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_id_value", id_value, 32'd0);
    chk("rst_ts_value", ts_value, 32'd0);

    // Auto-start after reset release.
    @(posedge clock);
    #1;
    sbq.push_back(mk(1, 0, 0, 0, EID, ETS, 1, 1, 5));
    reset_n = 1'b1;
    wait_sb(400);

    // Timestamp mismatch.
    run_check(EID, 32'h0000_0001, 0, 0, 0,
              0, 0, 1, 0, EID, 32'h0000_0001, 1, 1, 5);
    // ID mismatch: both words still read.
    run_check(32'h1234_5678, ETS, 0, 0, 0,
              0, 1, 0, 0, 32'h1234_5678, ETS, 1, 1, 5);
    // Ten stall cycles on each read.
    run_check(EID, ETS, 10, 0, 0,
              1, 0, 0, 0, EID, ETS, 1, 1, 25);
    // No response to word 0: three attempts, word 1 skipped.
    run_check(EID, ETS, 0, 1, 0,
              0, 0, 0, 1, EID, ETS, 3, 0, -1);
    // No response to word 1: word 0 captured, three attempts.
    run_check(32'hCAFE_0000, ETS, 0, 0, 1,
              0, 1, 0, 1, 32'hCAFE_0000, ETS, 1, 3, -1);

    // Start re-pulsed while busy.
    cfg_data[0]   = EID;
    cfg_data[1]   = ETS;
    cfg_wait      = 0;
    cfg_noresp[0] = 1'b0;
    cfg_noresp[1] = 1'b0;
    @(posedge clock);
    #1;
    sbq.push_back(mk(1, 0, 0, 0, EID, ETS, 1, 1, 5));
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_sb(400);
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("busy_after_restart", 32'(busy), 32'd0);

    // Reset while waiting for word 1; late response is stale.
    cfg_data[1]  = 32'hBAD0_0001;
    cfg_delay[1] = 5;
    @(posedge clock);
    #1;
    base1 = rd_cnt[1];
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (rd_cnt[1] == base1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("ts_read_seen", 32'(rd_cnt[1] - base1), 32'd1);
    cfg_data[1] = ETS;
    @(posedge clock);
    #1;
    chk("in_wt_ts_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_m_read", 32'(bus.m_read), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_err_id", 32'(err_id), 32'd0);
    chk("abort_err_ts", 32'(err_ts), 32'd0);
    chk("abort_err_timeout", 32'(err_timeout), 32'd0);
    chk("abort_id_value", id_value, 32'd0);
    chk("abort_ts_value", ts_value, 32'd0);
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    cfg_delay[1] = 1;
    sbq.push_back(mk(1, 0, 0, 0, EID, ETS, 1, 1, -1));
    reset_n = 1'b1;
    wait_sb(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h8765_4321, system ID value the hardware build must report at word 0.
REQ-002 Parameter EXPECTED_TS, default 32'h6951_52E4, build timestamp expected at word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles from read accept to readdatavalid.
REQ-004 Parameter MAX_RETRY, default 2, retries per word after a timeout.
REQ-005 Parameter AUTO_START, default 1, start one check automatically after reset release.
REQ-006 clock  in  1  single clock, all logic on its rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse requesting a check.
REQ-009 m_address  out  1  Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-010 m_read  out  1  Avalon-MM read request.
REQ-011 m_waitrequest  in  1  slave stall; m_read/m_address held while high.
REQ-012 m_readdata  in  32  read data, valid when m_readdatavalid is high.
REQ-013 m_readdatavalid  in  1  read response strobe.
REQ-014 busy  out  1  check in progress.
REQ-015 done  out  1  one-cycle pulse at end of a check.
REQ-016 pass  out  1  sticky: last check matched both words.
REQ-017 err_id / err_ts / err_timeout  out  1 each  sticky failure causes of last check.
REQ-018 id_value / ts_value  out  32 each  last captured words.

Function
REQ-019 States: IDLE, RD_ID, WT_ID, RD_TS, WT_TS, FINISH; one-hot or binary encoding is free.
REQ-020 IDLE -> RD_ID on start pulse, or in the first cycle after reset release when AUTO_START=1; on entry clear pass and all err_* flags.
REQ-021 RD_ID drives m_read=1, m_address=0; advances to WT_ID on the cycle m_waitrequest=0.
REQ-022 WT_ID: on m_readdatavalid capture id_value, set err_id if value != EXPECTED_ID, go to RD_TS.
REQ-023 RD_TS/WT_TS identical with m_address=1, ts_value, err_ts, EXPECTED_TS; WT_TS -> FINISH.
REQ-024 m_read is high only in RD_* states; exactly one read is issued per attempt.
REQ-025 Timeout counter resets on entry to WT_*; if it reaches TIMEOUT_CYCLES without readdatavalid, the attempt is abandoned and the same RD_* state is re-entered.
REQ-026 Retry counter per word; after MAX_RETRY+1 failed attempts, set err_timeout and go directly to FINISH (remaining word not read).
REQ-027 Readdatavalid arriving in RD_* states or after a timeout is ignored.
REQ-028 A data mismatch does not abort; both words are always read unless a timeout aborts.
REQ-029 FINISH: pulse done for one cycle, set pass = !(err_id|err_ts|err_timeout), return to IDLE.
REQ-030 busy = 1 in every state except IDLE; start while busy is ignored.
REQ-031 Latency with zero-wait slave, readdatavalid one cycle after accept: start to done = 5 cycles.
REQ-032 Counter widths sized by $clog2 of TIMEOUT_CYCLES+1 and MAX_RETRY+1; no wrap before limit.

Reset
REQ-033 reset_n low: state IDLE, m_read=0, m_address=0, busy=0, done=0, pass=0, all err_*=0, id_value=ts_value=0, counters 0.
REQ-034 Reset asserted mid-check aborts immediately without a done pulse; outstanding response after release is ignored.

Structure
REQ-035 Package sysid_check_pkg holds the state enum, word-address constants (ADDR_ID=0, ADDR_TS=1) and default expected values.
REQ-036 One sub-module sysid_check_timer: loadable down-counter with expired flag, used for the timeout.

Verification
REQ-039 Reset release, AUTO_START=1, responder returns 32'h8765_4321 / 32'h6951_52E4 -> done after 5 cycles, pass=1, all err_*=0.
REQ-040 start with word 1 returning 32'h0000_0001 -> pass=0, err_ts=1, err_id=0, ts_value=32'h0000_0001.
REQ-041 m_waitrequest held high 10 cycles on each read -> m_read/m_address stable throughout, correct pass, done at cycle 25.
REQ-042 Responder never asserts readdatavalid, TIMEOUT_CYCLES=8, MAX_RETRY=2 -> three reads at address 0, err_timeout=1, no address-1 read, done pulse.
REQ-043 reset_n pulsed low while in WT_TS -> all outputs at reset values, no done pulse; late readdatavalid ignored.
REQ-044 start re-pulsed while busy -> ignored, exactly one done pulse and two reads.
